// File: rtl/axi_rd_arbiter_2x1_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_state_e;

    localparam int REQ_DCACHE = 0;
    localparam int REQ_ICACHE = 1;

    localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_rd_arbiter_2x1_if.sv
// AR/R channel bundle; N lanes of request fields with a shared R data path.
interface axi_rd_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic [N*ADDR_W-1:0] araddr;
    logic [N*LEN_W-1:0]  arlen;
    logic [N*3-1:0]      arsize;
    logic [N*2-1:0]      arburst;
    logic [N-1:0]        arvalid;
    logic [N-1:0]        arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [N-1:0]        rvalid;
    logic [N-1:0]        rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter_2x1_rr_arb2.sv
// Combinational 2-way round-robin picker: on a tie the port not granted last time wins.
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       gnt_idx
);

    always_comb begin
        grant = req;
        if (req[REQ_DCACHE] && req[REQ_ICACHE]) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
        gnt_idx = grant[REQ_ICACHE];
    end

endmodule

// File: rtl/axi_rd_arbiter_2x1.sv
// Shares one AXI read channel between the data cache (port 0) and instruction cache (port 1),
// one burst in flight at a time, with an R-beat count check against the granted arlen.
module axi_rd_arbiter_2x1
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic     clk,
    input  logic     rst,
    axi_rd_if.slave  s,
    axi_rd_if.master m,
    output logic     rd_busy,
    output logic     rd_owner,
    output logic     rd_err
);

    rd_state_e         state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic              err_q, err_d;

    logic [1:0]        grant;
    logic              gnt_idx;
    logic              r_hs;

    logic [ADDR_W-1:0] req_addr  [2];
    logic [LEN_W-1:0]  req_len   [2];
    logic [2:0]        req_size  [2];
    logic [1:0]        req_burst [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_addr[gi]  = s.araddr[gi*ADDR_W +: ADDR_W];
        assign req_len[gi]   = s.arlen[gi*LEN_W +: LEN_W];
        assign req_size[gi]  = s.arsize[gi*3 +: 3];
        assign req_burst[gi] = s.arburst[gi*2 +: 2];
    end

    rr_arb2 u_rr_arb2 (
        .req        (s.arvalid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .gnt_idx    (gnt_idx)
    );

    // R payload is broadcast; only the owner's rvalid bit qualifies it.
    assign s.rdata  = m.rdata;
    assign s.rresp  = m.rresp;
    assign s.rlast  = m.rlast;

    assign m.araddr  = addr_q;
    assign m.arlen   = len_q;
    assign m.arsize  = size_q;
    assign m.arburst = burst_q;

    assign r_hs     = m.rvalid[0] && s.rready[owner_q];
    assign rd_busy  = (state_q != IDLE);
    assign rd_owner = owner_q;
    assign rd_err   = err_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        burst_d      = burst_q;
        err_d        = err_q;
        s.arready    = 2'b00;
        s.rvalid     = 2'b00;
        m.arvalid    = 1'b0;
        m.rready     = 1'b0;

        // Handshake outputs are forced low while reset is held.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (|s.arvalid) begin
                        s.arready    = grant;
                        owner_d      = gnt_idx;
                        last_grant_d = gnt_idx;
                        beat_cnt_d   = '0;
                        addr_d       = req_addr[gnt_idx];
                        len_d        = req_len[gnt_idx];
                        size_d       = req_size[gnt_idx];
                        burst_d      = req_burst[gnt_idx];
                        state_d      = ADDR;
                    end
                end
                ADDR: begin
                    m.arvalid = 1'b1;
                    if (m.arready[0]) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    s.rvalid[owner_q] = m.rvalid[0];
                    m.rready          = s.rready[owner_q];
                    if (r_hs) begin
                        beat_cnt_d = beat_cnt_q + {{LEN_W{1'b0}}, 1'b1};
                        // Early or late rlast is flagged, but only rlast ends the burst.
                        if (m.rlast != (beat_cnt_q == {1'b0, len_q})) begin
                            err_d = 1'b1;
                        end
                        if (m.rlast) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            beat_cnt_q   <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter_2x1.sv
// Bench for axi_rd_arbiter_2x1: requester drivers, a simple AXI slave memory and an R-beat scoreboard.
module tb_axi_rd_arbiter_2x1;
    import axi_arb_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk;
    logic rst;
    logic rd_busy, rd_owner, rd_err;

    axi_rd_if #(.N(2), .ADDR_W(32), .DATA_W(32), .LEN_W(8)) s_if ();
    axi_rd_if #(.N(1), .ADDR_W(32), .DATA_W(32), .LEN_W(8)) m_if ();

    axi_rd_arbiter_2x1 #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (s_if),
        .m        (m_if),
        .rd_busy  (rd_busy),
        .rd_owner (rd_owner),
        .rd_err   (rd_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    req_t  pend [2][$];
    beat_t exp_q [2][$];
    int    grant_log[$];
    int    grant_cyc [2];
    int    rlast_cyc [2];
    int    beats_seen [2];
    int    early_last = -1;
    bit    mem_active = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] beat_data(logic [31:0] addr, int beat);
        return (addr + 32'(beat * 4)) ^ 32'h5A5A_0000;
    endfunction

    task automatic issue(int p, logic [31:0] addr, int len, int last_at);
        req_t  r;
        beat_t b;
        r.addr = addr;
        r.len  = len;
        pend[p].push_back(r);
        for (int i = 0; i <= last_at; i++) begin
            b.data = beat_data(addr, i);
            b.resp = 2'(i & 1);
            b.last = (i == last_at);
            exp_q[p].push_back(b);
        end
        $display("issue: port %0d addr %08h arlen %0d beats %0d", p, addr, len, last_at + 1);
    endtask

    // Requester drivers: hold arvalid until accepted, then present the next queued request.
    initial begin
        bit acc [2];
        s_if.arvalid = 2'b00;
        s_if.araddr  = '0;
        s_if.arlen   = '0;
        s_if.arsize  = '0;
        s_if.arburst = '0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                acc[p] = !rst && s_if.arvalid[p] && s_if.arready[p];
                if (acc[p]) begin
                    grant_log.push_back(p);
                    grant_cyc[p] = cyc;
                    n_cmp++;
                    if (rd_busy !== 1'b0 || mem_active) begin
                        n_fail++;
                        $display("FAIL one_in_flight: grant to port %0d while busy=%0b mem_active=%0b", p, rd_busy, mem_active);
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (acc[p] && pend[p].size() > 0) void'(pend[p].pop_front());
                if (pend[p].size() > 0) begin
                    s_if.arvalid[p]           = 1'b1;
                    s_if.araddr[p*32 +: 32]   = pend[p][0].addr;
                    s_if.arlen[p*8 +: 8]      = 8'(pend[p][0].len);
                    s_if.arsize[p*3 +: 3]     = 3'd2;
                    s_if.arburst[p*2 +: 2]    = BURST_INCR;
                end else begin
                    s_if.arvalid[p] = 1'b0;
                end
            end
        end
    end

    // Slave memory: one-cycle AR wait, then a continuous R burst with a fixed data pattern.
    initial begin
        bit          ar_hs, ar_wait, r_hs, r_last, rst_s;
        logic [31:0] mem_addr;
        int          mem_len, mem_beat;
        m_if.arready = 1'b0;
        m_if.rvalid  = 1'b0;
        m_if.rdata   = '0;
        m_if.rresp   = '0;
        m_if.rlast   = 1'b0;
        mem_addr = '0;
        mem_len  = 0;
        mem_beat = 0;
        forever begin
            @(negedge clk);
            rst_s   = rst;
            ar_hs   = m_if.arvalid[0] && m_if.arready[0];
            ar_wait = m_if.arvalid[0] && !m_if.arready[0];
            r_hs    = m_if.rvalid[0] && m_if.rready[0];
            r_last  = m_if.rlast;
            if (ar_hs) begin
                mem_addr = m_if.araddr;
                mem_len  = int'(m_if.arlen);
            end
            @(posedge clk);
            #1;
            if (rst_s) begin
                mem_active   = 0;
                m_if.arready = 1'b0;
            end else begin
                m_if.arready = ar_wait;
                if (ar_hs) begin
                    mem_active = 1;
                    mem_beat   = 0;
                end else if (r_hs) begin
                    if (r_last) mem_active = 0;
                    else        mem_beat++;
                end
            end
            m_if.rvalid = mem_active;
            m_if.rdata  = beat_data(mem_addr, mem_beat);
            m_if.rresp  = 2'(mem_beat & 1);
            m_if.rlast  = mem_active && ((mem_beat == mem_len) || (mem_beat == early_last));
        end
    end

    // Scoreboard: every requester-side R handshake is checked against the expected beat queue.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (s_if.rvalid === 2'b11) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rvalid_onehot: s_rvalid=%b required one-hot or zero", s_if.rvalid);
                end
                for (int p = 0; p < 2; p++) begin
                    if (s_if.rvalid[p] && s_if.rready[p]) begin
                        n_cmp++;
                        beats_seen[p]++;
                        if (s_if.rlast) rlast_cyc[p] = cyc;
                        if (exp_q[p].size() == 0) begin
                            n_fail++;
                            $display("FAIL r_beat: port %0d unexpected beat data %08h", p, s_if.rdata);
                        end else begin
                            e = exp_q[p].pop_front();
                            $display("beat: port %0d data %08h resp %0d last %0b", p, s_if.rdata, s_if.rresp, s_if.rlast);
                            if (s_if.rdata !== e.data || s_if.rresp !== e.resp || s_if.rlast !== e.last) begin
                                n_fail++;
                                $display("FAIL r_beat: port %0d got %08h/%0d/%0b required %08h/%0d/%0b",
                                         p, s_if.rdata, s_if.rresp, s_if.rlast, e.data, e.resp, e.last);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic wait_drain(string name);
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (pend[0].size() == 0) && (pend[1].size() == 0) &&
                   (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (rd_busy === 1'b0);
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: busy=%0b pend=%0d/%0d exp=%0d/%0d required all drained",
                     name, rd_busy, pend[0].size(), pend[1].size(), exp_q[0].size(), exp_q[1].size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.rready = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rd_busy, rd_owner, rd_err, m_if.arvalid, m_if.rready, s_if.arready, s_if.rvalid} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy/owner/err/arvalid/rready/arready/rvalid=%b required 0",
                     {rd_busy, rd_owner, rd_err, m_if.arvalid, m_if.rready, s_if.arready, s_if.rvalid});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_port1_alone();
        bit seen = 0;
        issue(1, 32'h1FC0_0000, 7, 7);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = s_if.arvalid[1];
        end
        n_cmp++;
        if (s_if.arready !== 2'b10) begin
            n_fail++;
            $display("FAIL p1_arready: s_arready=%b required 10", s_if.arready);
        end
        @(negedge clk);
        n_cmp++;
        if (m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h1FC0_0000 || m_if.arlen !== 8'd7 ||
            m_if.arburst !== BURST_INCR || m_if.arsize !== 3'd2) begin
            n_fail++;
            $display("FAIL p1_ar_fields: arvalid=%0b addr=%08h len=%0d required 1/1fc00000/7",
                     m_if.arvalid, m_if.araddr, m_if.arlen);
        end
        wait_drain("p1");
        n_cmp++;
        if (rd_err !== 1'b0 || rd_owner !== 1'b1 || beats_seen[0] !== 0 || beats_seen[1] !== 8) begin
            n_fail++;
            $display("FAIL p1_done: err=%0b owner=%0b beats=%0d/%0d required 0/1/0/8",
                     rd_err, rd_owner, beats_seen[0], beats_seen[1]);
        end
    endtask

    task automatic test_tie_after_reset();
        rst = 1'b1;
        issue(0, 32'h0000_1000, 3, 3);
        issue(1, 32'h1FC0_0100, 1, 1);
        grant_log.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_drain("tie");
        n_cmp++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
            n_fail++;
            $display("FAIL tie_order: %0d grants first=%0d required 2 grants order 0,1",
                     grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
        end
        n_cmp++;
        if (grant_cyc[1] != rlast_cyc[0] + 1) begin
            n_fail++;
            $display("FAIL tie_bubble: port1 grant cycle %0d required %0d", grant_cyc[1], rlast_cyc[0] + 1);
        end
    endtask

    task automatic test_back_to_back();
        int order [4] = '{0, 1, 0, 1};
        grant_log.delete();
        issue(0, 32'h0000_2000, 2, 2);
        issue(1, 32'h1FC0_0200, 3, 3);
        issue(0, 32'h0000_3000, 0, 0);
        issue(1, 32'h1FC0_0300, 4, 4);
        wait_drain("b2b");
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (grant_log.size() <= i || grant_log[i] != order[i]) begin
                n_fail++;
                $display("FAIL b2b_order: grant %0d got %0d required %0d",
                         i, grant_log.size() > i ? grant_log[i] : -1, order[i]);
            end
        end
    endtask

    task automatic test_rready_stall();
        bit ok = 0;
        beats_seen[0] = 0;
        issue(0, 32'h0000_4000, 7, 7);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            ok = (beats_seen[0] >= 3);
        end
        #1 s_if.rready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (m_if.rready !== 1'b0 || s_if.rvalid !== 2'b01) begin
                n_fail++;
                $display("FAIL stall_rready: cycle %0d m_rready=%0b s_rvalid=%b required 0/01",
                         i, m_if.rready, s_if.rvalid);
            end
        end
        @(posedge clk);
        #1 s_if.rready = 2'b11;
        wait_drain("stall");
        n_cmp++;
        if (beats_seen[0] !== 8) begin
            n_fail++;
            $display("FAIL stall_beats: %0d beats required 8", beats_seen[0]);
        end
    endtask

    task automatic test_len_error();
        early_last = 1;
        issue(1, 32'h1FC0_0400, 3, 1);
        wait_drain("lenerr");
        early_last = -1;
        n_cmp++;
        if (rd_err !== 1'b1 || rd_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len_err_set: err=%0b busy=%0b required 1/0", rd_err, rd_busy);
        end
        issue(0, 32'h0000_5000, 1, 1);
        issue(1, 32'h1FC0_0500, 2, 2);
        wait_drain("lenerr2");
        n_cmp++;
        if (rd_err !== 1'b1) begin
            n_fail++;
            $display("FAIL len_err_sticky: err=%0b required 1", rd_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok = 0;
        beats_seen[0] = 0;
        issue(0, 32'h0000_6000, 5, 5);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            ok = (beats_seen[0] >= 4);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rd_busy, rd_owner, rd_err, m_if.arvalid, m_if.rready, s_if.arready, s_if.rvalid} !== 9'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy/owner/err/arvalid/rready/arready/rvalid=%b required 0",
                     {rd_busy, rd_owner, rd_err, m_if.arvalid, m_if.rready, s_if.arready, s_if.rvalid});
        end
        exp_q[0].delete();
        exp_q[1].delete();
        pend[0].delete();
        pend[1].delete();
        grant_log.delete();
        issue(1, 32'h1FC0_0600, 0, 0);
        issue(0, 32'h0000_7000, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_drain("postrst");
        n_cmp++;
        if (grant_log.size() < 1 || grant_log[0] != 0) begin
            n_fail++;
            $display("FAIL postrst_first: first grant %0d required 0", grant_log.size() > 0 ? grant_log[0] : -1);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_if.rready = 2'b11;
        beats_seen[0] = 0;
        beats_seen[1] = 0;
        test_reset();
        test_port1_alone();
        test_tie_after_reset();
        test_back_to_back();
        test_rready_stall();
        test_len_error();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
